mem_search_arbiter: RTL

Owns the DEPTH x WIDTH register array (default 16 x 8) and shares its single access port among three users: requester A, requester B and an internal search engine. The search engine scans the array one entry per cycle and reports whether a key value is present and where. This is the sequential, arbitrated equivalent of an inside-set membership test on the array. It sits between the datapath write/read clients and any logic that needs a membership check on array contents.

---
 rtl/mem_search_pkg.sv | 25 ++
 rtl/rr_arbiter3.sv | 31 +++
 rtl/mem_search_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_search_pkg.sv
// rtl/mem_search_pkg.sv - shared types and helpers for the arbitrated search array
package mem_search_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } srch_state_t;

    typedef enum logic [1:0] {
        REQ_A = 2'd0,
        REQ_B = 2'd1,
        REQ_S = 2'd2
    } req_id_t;

    // Modulo-3 advance of a round-robin slot; operands are always below 3.
    function automatic logic [1:0] rr_next(input logic [1:0] slot, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, slot} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - three-way round-robin grant selection (A -> B -> S -> A)
module rr_arbiter3
    import mem_search_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [1:0]         o_ptr_nxt
);

    logic [1:0] w_slot;
    logic       w_found;

    // Scan slots starting at the pointer; the first requester wins and the
    // pointer moves past it. With no requesters the pointer holds.
    always_comb begin
        o_gnt     = '0;
        o_ptr_nxt = i_ptr;
        w_slot    = i_ptr;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot = rr_next(i_ptr, 2'(i));
            if (!w_found && i_req[w_slot]) begin
                o_gnt[w_slot] = 1'b1;
                o_ptr_nxt     = rr_next(w_slot, 2'd1);
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_search_arbiter.sv
// rtl/mem_search_arbiter.sv - register array shared by two requesters and a linear key search
module mem_search_arbiter
    import mem_search_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rsel,
    input  logic             srch_start,
    input  logic [WIDTH-1:0] srch_key,
    output logic             srch_busy,
    output logic             srch_done,
    output logic             srch_hit,
    output logic [AW-1:0]    srch_idx
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    srch_state_t        r_state;
    logic [1:0]         r_rr_ptr;
    logic [AW-1:0]      r_scan_idx;
    logic [WIDTH-1:0]   r_key;
    logic               r_hit;
    logic [AW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_rvalid;
    logic               r_rsel;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [1:0]         w_rr_ptr_nxt;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [AW-1:0]      w_addr;
    logic [WIDTH-1:0]   w_wdata;
    logic               w_scan_match;

    always_comb begin
        w_req        = '0;
        w_req[REQ_A] = a_req;
        w_req[REQ_B] = b_req;
        w_req[REQ_S] = (r_state == SCAN);
    end

    rr_arbiter3 u_arb (
        .i_req     (w_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_ptr_nxt (w_rr_ptr_nxt)
    );

    assign w_wr_en      = (w_gnt[REQ_A] & a_we) | (w_gnt[REQ_B] & b_we);
    assign w_rd_en      = (w_gnt[REQ_A] & ~a_we) | (w_gnt[REQ_B] & ~b_we);
    assign w_addr       = w_gnt[REQ_B] ? b_addr : a_addr;
    assign w_wdata      = w_gnt[REQ_B] ? b_wdata : a_wdata;
    assign w_scan_match = (r_mem[r_scan_idx] == r_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state    <= IDLE;
            r_rr_ptr   <= REQ_A;
            r_scan_idx <= '0;
            r_key      <= '0;
            r_hit      <= 1'b0;
            r_idx      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rsel     <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;

            // Reads sample the pre-write contents because both use the same edge.
            if (w_wr_en) begin
                r_mem[w_addr] <= w_wdata;
            end
            r_rvalid <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= r_mem[w_addr];
                r_rsel  <= w_gnt[REQ_B];
            end

            case (r_state)
                IDLE: begin
                    if (srch_start) begin
                        r_key      <= srch_key;
                        r_scan_idx <= '0;
                        r_hit      <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_gnt[REQ_S]) begin
                        if (w_scan_match) begin
                            r_hit   <= 1'b1;
                            r_idx   <= r_scan_idx;
                            r_state <= DONE;
                        end else if (r_scan_idx == AW'(DEPTH - 1)) begin
                            r_hit   <= 1'b0;
                            r_idx   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_scan_idx <= r_scan_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_gnt     = w_gnt[REQ_A];
    assign b_gnt     = w_gnt[REQ_B];
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign rsel      = r_rsel;
    assign srch_busy = (r_state != IDLE);
    assign srch_done = (r_state == DONE);
    assign srch_hit  = r_hit;
    assign srch_idx  = r_idx;

endmodule
